// File: rtl/registro_jogada.sv
// Shot register for a 3x3 battleship-style game: captures a confirmed coordinate,
// classifies it as hit / miss / repeat, keeps shot and hit tallies and detects game end.
module registro_jogada #(
   parameter int MAX_TIROS    = 6,
   parameter int EXIBE_CICLOS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       confirma,
   input  logic       s1,
   input  logic       s2,
   input  logic [2:0] linha,
   input  logic [2:0] coluna,
   input  logic [8:0] alvo,
   output logic [8:0] mapa_tiros,
   output logic       acerto,
   output logic       agua,
   output logic       repetido,
   output logic [3:0] tiros,
   output logic [3:0] acertos,
   output logic       ocupado,
   output logic       fim_jogo,
   output logic       vitoria
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      AVALIA = 2'd1,
      EXIBE  = 2'd2,
      FIM    = 2'd3
   } estado_t;

   localparam logic [3:0] MAX_T      = 4'(MAX_TIROS);
   localparam logic [3:0] CONTA_MAX  = 4'd9;
   localparam logic [7:0] EXIBE_ULT  = 8'(EXIBE_CICLOS - 1);

   estado_t    estado_q, estado_d;
   logic [2:0] sync_q, sync_d;
   logic [3:0] idx_q, idx_d;
   logic [8:0] mapa_q, mapa_d;
   logic [3:0] tiros_q, tiros_d;
   logic [3:0] acertos_q, acertos_d;
   logic [7:0] cnt_q, cnt_d;
   logic       acerto_q, acerto_d;
   logic       agua_q, agua_d;
   logic       repetido_q, repetido_d;
   logic       vitoria_q, vitoria_d;

   logic       press;
   logic       coord_ok;
   logic       acertou_tudo;
   logic [3:0] idx_novo;
   logic [3:0] total_alvos;

   function automatic logic um_quente(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

   function automatic logic [3:0] codifica(input logic [2:0] v);
      logic [3:0] r;
      r = 4'd0;
      if (v[1]) r = 4'd1;
      if (v[2]) r = 4'd2;
      return r;
   endfunction

   function automatic logic [3:0] popcount9(input logic [8:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 9; i++) begin
         n = n + {3'd0, v[i]};
      end
      return n;
   endfunction

   // Stage 0 and 1 synchronise the button; stage 2 remembers the previous level.
   assign sync_d       = {sync_q[1:0], confirma};
   assign press        = sync_q[1] & ~sync_q[2];

   assign coord_ok     = um_quente(linha) && um_quente(coluna);
   assign idx_novo     = (codifica(linha) << 1) + codifica(linha) + codifica(coluna);
   assign total_alvos  = popcount9(alvo);
   assign acertou_tudo = (alvo != 9'd0) && (acertos_q == total_alvos);

   always_comb begin
      estado_d   = estado_q;
      idx_d      = idx_q;
      mapa_d     = mapa_q;
      tiros_d    = tiros_q;
      acertos_d  = acertos_q;
      cnt_d      = cnt_q;
      acerto_d   = acerto_q;
      agua_d     = agua_q;
      repetido_d = repetido_q;
      vitoria_d  = vitoria_q;

      case (estado_q)
         IDLE: begin
            if (press) begin
               if (s2) begin
                  mapa_d     = 9'd0;
                  tiros_d    = 4'd0;
                  acertos_d  = 4'd0;
                  acerto_d   = 1'b0;
                  agua_d     = 1'b0;
                  repetido_d = 1'b0;
                  vitoria_d  = 1'b0;
               end else if (s1 && coord_ok) begin
                  idx_d    = idx_novo;
                  estado_d = AVALIA;
               end
            end
         end

         AVALIA: begin
            cnt_d    = EXIBE_ULT;
            estado_d = EXIBE;
            if (mapa_q[idx_q]) begin
               repetido_d = 1'b1;
            end else begin
               mapa_d[idx_q] = 1'b1;
               if (tiros_q < CONTA_MAX) tiros_d = tiros_q + 4'd1;
               if (alvo[idx_q]) begin
                  acerto_d = 1'b1;
                  if (acertos_q < CONTA_MAX) acertos_d = acertos_q + 4'd1;
               end else begin
                  agua_d = 1'b1;
               end
            end
         end

         EXIBE: begin
            if (cnt_q == 8'd0) begin
               acerto_d   = 1'b0;
               agua_d     = 1'b0;
               repetido_d = 1'b0;
               // A win takes precedence when the last shot both hits and exhausts the limit.
               if (acertou_tudo || (tiros_q == MAX_T)) begin
                  vitoria_d = acertou_tudo;
                  estado_d  = FIM;
               end else begin
                  estado_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end

         FIM: begin
            if (press && s2) begin
               mapa_d     = 9'd0;
               tiros_d    = 4'd0;
               acertos_d  = 4'd0;
               acerto_d   = 1'b0;
               agua_d     = 1'b0;
               repetido_d = 1'b0;
               vitoria_d  = 1'b0;
               estado_d   = IDLE;
            end
         end

         default: estado_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q   <= IDLE;
         sync_q     <= 3'd0;
         idx_q      <= 4'd0;
         mapa_q     <= 9'd0;
         tiros_q    <= 4'd0;
         acertos_q  <= 4'd0;
         cnt_q      <= 8'd0;
         acerto_q   <= 1'b0;
         agua_q     <= 1'b0;
         repetido_q <= 1'b0;
         vitoria_q  <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         sync_q     <= sync_d;
         idx_q      <= idx_d;
         mapa_q     <= mapa_d;
         tiros_q    <= tiros_d;
         acertos_q  <= acertos_d;
         cnt_q      <= cnt_d;
         acerto_q   <= acerto_d;
         agua_q     <= agua_d;
         repetido_q <= repetido_d;
         vitoria_q  <= vitoria_d;
      end
   end

   assign mapa_tiros = mapa_q;
   assign tiros      = tiros_q;
   assign acertos    = acertos_q;
   assign acerto     = acerto_q;
   assign agua       = agua_q;
   assign repetido   = repetido_q;
   assign vitoria    = vitoria_q;
   assign ocupado    = (estado_q == AVALIA) || (estado_q == EXIBE);
   assign fim_jogo   = (estado_q == FIM);

endmodule

// File: doc/registro_jogada.md
REGISTRO_JOGADA -- requirements
Module: registro_jogada

Interface
REQ-001 Parameter MAX_TIROS, default 6, meaning shot limit per game; legal range 1..9.
REQ-002 Parameter EXIBE_CICLOS, default 8, meaning clock cycles each result flag stays visible; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 confirma  input  1  raw confirm pushbutton, active-high, asynchronous to clk.
REQ-006 s1  input  1  coordinate mode active, from the mode/coordinate decoder.
REQ-007 s2  input  1  clear mode active, from the mode/coordinate decoder.
REQ-008 linha  input  3  row strobes {s5,s4,s3}; bit r = row r.
REQ-009 coluna  input  3  column strobes {s8,s7,s6}; bit c = column c.
REQ-010 alvo  input  9  target map; bit index = 3*row + col; static during a game.
REQ-011 mapa_tiros  output  9  cells already fired; same indexing as alvo.
REQ-012 acerto / agua / repetido  output  1 each  hit / miss / repeated-cell flags.
REQ-013 tiros  output  4  valid shots taken.
REQ-014 acertos  output  4  hits scored.
REQ-015 ocupado  output  1  high in any state other than IDLE and FIM.
REQ-016 fim_jogo / vitoria  output  1 each  game over / game won.

Function
REQ-017 confirma is synchronised by two flip-flops; a press is the rising edge of the second stage (third register holds previous value); one press yields exactly one event.
REQ-018 FSM states: IDLE, AVALIA, EXIBE, FIM.
REQ-019 IDLE, press with s2=1: clear mapa_tiros, tiros, acertos and all flags; remain IDLE; s2 has priority over s1.
REQ-020 IDLE, press with s1=1, s2=0, linha and coluna each exactly one-hot: capture idx = 3*row+col; go to AVALIA.
REQ-021 IDLE, press with any other input combination (zero or multiple strobes, no mode): ignore; no state or output change.
REQ-022 AVALIA, one cycle: if mapa_tiros[idx]=1, set repetido and change no counter; else set mapa_tiros[idx] and increment tiros, then set acerto and increment acertos if alvo[idx]=1, else set agua; go to EXIBE.
REQ-023 Exactly one of acerto/agua/repetido is high during EXIBE; all three are low in every other state.
REQ-024 EXIBE lasts EXIBE_CICLOS cycles, then clears flags and goes to FIM if (alvo != 0 and acertos == popcount(alvo)) or tiros == MAX_TIROS, else to IDLE.
REQ-025 vitoria is set on entry to FIM only when the hit condition caused it; when hit-complete and shot limit occur together, vitoria=1.
REQ-026 FIM: fim_jogo=1; only a press with s2=1 clears everything (REQ-019 action) and returns to IDLE; every other press is ignored.
REQ-027 Presses arriving in AVALIA or EXIBE are discarded and are not queued.
REQ-028 alvo=0: vitoria can never assert; game ends only by shot limit.
REQ-029 Latency: confirm high sampled at edge 0 gives a flag visible after edge 3.
REQ-030 tiros and acertos never exceed 9 and never wrap.

Reset
REQ-031 rst_n low immediately forces state IDLE, sync registers 0, mapa_tiros=0, tiros=0, acertos=0, all flags, ocupado, fim_jogo and vitoria 0, independent of clk.
REQ-032 Reset asserted mid-EXIBE or in FIM aborts the operation; after release the block is in IDLE with no pending press.

Verification
REQ-033 alvo=9'h001, s1=1, linha=001, coluna=001, one press -> acerto high exactly 8 cycles; tiros=1, acertos=1, mapa_tiros=9'h001; then FIM with vitoria=1.
REQ-034 alvo=9'h100, fire (0,0) twice -> first press: agua, tiros=1; second press: repetido, tiros still 1.
REQ-035 linha=011, coluna=001, press -> no response; state IDLE; all outputs unchanged.
REQ-036 alvo=9'h100, six distinct misses -> tiros=6, fim_jogo=1, vitoria=0; press with s1 ignored; press with s2 clears all outputs to 0.
REQ-037 Press held high 50 cycles -> exactly one shot counted; second press during EXIBE -> discarded.
REQ-038 rst_n pulsed low mid-EXIBE, asynchronous to clk -> all outputs 0 before next clk edge; IDLE after release.
